// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: drives the PLL reset, qualifies extlock, then releases per-channel resets staggered.
// Optional `define PLL_SUP_RELOCK_CNT_EN adds an 8-bit saturating lock-loss counter output (relock_cnt).
module pll_lock_supervisor #(
    parameter int NUM_CH         = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 24000,
    parameter int LOCK_STABLE    = 240,
    parameter int STAGGER        = 64,
    parameter int MAX_RETRY      = 3
) (
    input  logic                           refclk,
    input  logic                           reset,
    input  logic                           extlock,
    output logic                           pll_reset,
    output logic [NUM_CH-1:0]              ch_rst,
    output logic                           ready,
    output logic                           fail,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
`ifdef PLL_SUP_RELOCK_CNT_EN
    ,
    output logic [7:0]                     relock_cnt
`endif
);

    localparam int RC_W    = $clog2(MAX_RETRY + 1);
    localparam int SEQ_LEN = NUM_CH * STAGGER;
    localparam int T_A     = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int T_B     = (T_A > LOCK_STABLE) ? T_A : LOCK_STABLE;
    localparam int T_MAX   = (T_B > SEQ_LEN) ? T_B : SEQ_LEN;
    localparam int TIMER_W = $clog2(T_MAX);
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [TIMER_W-1:0] T_RST_LAST    = TIMER_W'(PLL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] T_LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] T_STABLE_LAST = TIMER_W'(LOCK_STABLE - 1);
    localparam logic [RC_W-1:0]    RETRY_LIMIT   = RC_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0]   LAST_CH       = IDX_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        ST_RST_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_SEQ,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [IDX_W-1:0]    ch_idx_q, ch_idx_d;
    logic [RC_W-1:0]     retry_cnt_q, retry_cnt_d;
    logic                pll_reset_q, pll_reset_d;
    logic [NUM_CH-1:0]   ch_rst_q, ch_rst_d;
    logic                ready_q, ready_d;
    logic                fail_q, fail_d;
    logic                sync1_q, lock_s_q;
    logic                release_now;
    logic                lock_lost;
    logic [TIMER_W-1:0]  rel_target;

    // extlock is asynchronous to refclk: plain two-flop synchroniser
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= extlock;
            lock_s_q <= sync1_q;
        end
    end

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RST_PLL;
            timer_q     <= '0;
            ch_idx_q    <= '0;
            retry_cnt_q <= '0;
            pll_reset_q <= 1'b1;
            ch_rst_q    <= '1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ch_idx_q    <= ch_idx_d;
            retry_cnt_q <= retry_cnt_d;
            pll_reset_q <= pll_reset_d;
            ch_rst_q    <= ch_rst_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        retry_cnt_d = retry_cnt_q;
        release_now = 1'b0;
        lock_lost   = 1'b0;
        rel_target  = TIMER_W'((int'(ch_idx_q) + 1) * STAGGER - 1);
        case (state_q)
            ST_RST_PLL: begin
                if (timer_q == T_RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // a lock seen on the timeout cycle takes priority over the retry
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                end else if (timer_q == T_LOCK_LAST) begin
                    retry_cnt_d = retry_cnt_q + RC_W'(1);
                    state_d     = (retry_cnt_d == RETRY_LIMIT) ? ST_FAIL : ST_RST_PLL;
                end
            end
            ST_STABLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (timer_q == T_STABLE_LAST) begin
                    state_d     = ST_SEQ;
                    retry_cnt_d = '0;
                    ch_idx_d    = '0;
                end
            end
            ST_SEQ: begin
                if (!lock_s_q) begin
                    lock_lost = 1'b1;
                    state_d   = ST_RST_PLL;
                end else if (timer_q == rel_target) begin
                    release_now = 1'b1;
                    if (ch_idx_q == LAST_CH) state_d = ST_RUN;
                    else                     ch_idx_d = ch_idx_q + IDX_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    lock_lost = 1'b1;
                    state_d   = ST_RST_PLL;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RST_PLL;
            end
        endcase

        // RUN and FAIL are open-ended, so the timer parks at zero there instead of wrapping
        if (state_d != state_q)                         timer_d = '0;
        else if (state_q == ST_RUN || state_q == ST_FAIL) timer_d = timer_q;
        else                                            timer_d = timer_q + TIMER_W'(1);
    end

    always_comb begin
        pll_reset_d = (state_d == ST_RST_PLL);
        ready_d     = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
        ch_rst_d    = '1;
        if (state_d == ST_SEQ || state_d == ST_RUN) begin
            ch_rst_d = ch_rst_q;
            if (release_now) ch_rst_d[ch_idx_q] = 1'b0;
        end
    end

`ifdef PLL_SUP_RELOCK_CNT_EN
    logic [7:0] relock_cnt_q, relock_cnt_d;

    always_comb begin
        relock_cnt_d = relock_cnt_q;
        if (lock_lost && relock_cnt_q != 8'hFF) relock_cnt_d = relock_cnt_q + 8'd1;
    end

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) relock_cnt_q <= '0;
        else       relock_cnt_q <= relock_cnt_d;
    end

    assign relock_cnt = relock_cnt_q;
`endif

    assign pll_reset = pll_reset_q;
    assign ch_rst    = ch_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor using small timing parameters; cycle counts are hand-derived.
module tb_pll_lock_supervisor;

    localparam int NUM_CH         = 4;
    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 16;
    localparam int LOCK_STABLE    = 8;
    localparam int STAGGER        = 4;
    localparam int MAX_RETRY      = 3;

    logic       refclk;
    logic       reset;
    logic       extlock;
    logic       pll_reset;
    logic [3:0] ch_rst;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
`ifdef PLL_SUP_RELOCK_CNT_EN
    logic [7:0] relock_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pll_lock_supervisor #(
        .NUM_CH        (NUM_CH),
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .LOCK_STABLE   (LOCK_STABLE),
        .STAGGER       (STAGGER),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .refclk    (refclk),
        .reset     (reset),
        .extlock   (extlock),
        .pll_reset (pll_reset),
        .ch_rst    (ch_rst),
        .ready     (ready),
        .fail      (fail),
        .retry_cnt (retry_cnt)
`ifdef PLL_SUP_RELOCK_CNT_EN
        ,
        .relock_cnt(relock_cnt)
`endif
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench just after edge E0 with reset released; the next edge is E1.
    task automatic start(input logic lk);
        reset   = 1'b1;
        extlock = lk;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        extlock = 1'b1;
        step(2);
        chk("rst_pll_reset", 32'(pll_reset), 32'd1);
        chk("rst_ch_rst",    32'(ch_rst),    32'hF);
        chk("rst_ready",     32'(ready),     32'd0);
        chk("rst_fail",      32'(fail),      32'd0);
        chk("rst_retry",     32'(retry_cnt), 32'd0);
        reset = 1'b0;

        // Lock present from the start: RST_PLL E1..E4, STABLE at E5, SEQ at E13
        step(3);  chk("s1_pll_hold",  32'(pll_reset), 32'd1);
        step(1);  chk("s1_pll_rel",   32'(pll_reset), 32'd0);
        step(12); chk("s1_ch_e16",    32'(ch_rst),    32'hF);
        step(1);  chk("s1_ch_e17",    32'(ch_rst),    32'hE);
        step(3);  chk("s1_ch_e20",    32'(ch_rst),    32'hE);
        step(1);  chk("s1_ch_e21",    32'(ch_rst),    32'hC);
        step(4);  chk("s1_ch_e25",    32'(ch_rst),    32'h8);
        step(3);  chk("s1_ready_e28", 32'(ready),     32'd0);
        step(1);  chk("s1_ch_e29",    32'(ch_rst),    32'h0);
        chk("s1_ready_e29", 32'(ready),     32'd1);
        chk("s1_fail",      32'(fail),      32'd0);
        chk("s1_retry",     32'(retry_cnt), 32'd0);

        // One-cycle lock glitch in RUN: loss seen at F3, restart stagger
        extlock = 1'b0;
        step(1);
        extlock = 1'b1;
        step(1);  chk("s4_ready_f2", 32'(ready),     32'd1);
        step(1);  chk("s4_ch_f3",    32'(ch_rst),    32'hF);
        chk("s4_ready_f3", 32'(ready),     32'd0);
        chk("s4_pll_f3",   32'(pll_reset), 32'd1);
`ifdef PLL_SUP_RELOCK_CNT_EN
        chk("s4_relock_f3", 32'(relock_cnt), 32'd1);
`endif
        step(3);  chk("s4_pll_f6",   32'(pll_reset), 32'd1);
        step(1);  chk("s4_pll_f7",   32'(pll_reset), 32'd0);
        step(24); chk("s4_ch_f31",   32'(ch_rst),    32'h8);
        step(1);  chk("s4_ch_f32",   32'(ch_rst),    32'h0);
        chk("s4_ready_f32", 32'(ready),     32'd1);
        chk("s4_retry_f32", 32'(retry_cnt), 32'd0);
`ifdef PLL_SUP_RELOCK_CNT_EN
        chk("s4_relock_f32", 32'(relock_cnt), 32'd1);
`endif

        // Asynchronous reset in SEQ after ch_rst[1] released
        start(1'b1);
        step(21); chk("s5_ch_e21", 32'(ch_rst), 32'hC);
        #2 reset = 1'b1;
        #1;
        chk("s5_async_ch",    32'(ch_rst),    32'hF);
        chk("s5_async_pll",   32'(pll_reset), 32'd1);
        chk("s5_async_ready", 32'(ready),     32'd0);
`ifdef PLL_SUP_RELOCK_CNT_EN
        chk("s5_async_relock", 32'(relock_cnt), 32'd0);
`endif

        // No lock: timeouts at E20, E40, E60 -> FAIL
        start(1'b0);
        step(19); chk("s2_retry_e19", 32'(retry_cnt), 32'd0);
        chk("s2_pll_e19", 32'(pll_reset), 32'd0);
        step(1);  chk("s2_retry_e20", 32'(retry_cnt), 32'd1);
        chk("s2_pll_e20", 32'(pll_reset), 32'd1);
        step(4);  chk("s2_pll_e24",   32'(pll_reset), 32'd0);
        step(16); chk("s2_retry_e40", 32'(retry_cnt), 32'd2);
        step(19); chk("s2_fail_e59",  32'(fail),      32'd0);
        step(1);  chk("s2_fail_e60",  32'(fail),      32'd1);
        chk("s2_retry_e60", 32'(retry_cnt), 32'd3);
        chk("s2_pll_e60",   32'(pll_reset), 32'd0);
        chk("s2_ch_e60",    32'(ch_rst),    32'hF);
        extlock = 1'b1;
        step(10); chk("s2_fail_held", 32'(fail),      32'd1);
        chk("s2_pll_held", 32'(pll_reset), 32'd0);
        chk("s2_ch_held",  32'(ch_rst),    32'hF);

        // Short lock pulse during STABLE: back to WAIT_LOCK at E13, then full sequence
        start(1'b0);
        step(5);
        extlock = 1'b1;
        step(5);
        extlock = 1'b0;
        step(2);  chk("s3_ch_e12",  32'(ch_rst),    32'hF);
        chk("s3_pll_e12", 32'(pll_reset), 32'd0);
        step(1);
        extlock = 1'b1;
        step(14); chk("s3_ch_e27",    32'(ch_rst), 32'hF);
        step(1);  chk("s3_ch_e28",    32'(ch_rst), 32'hE);
        step(11); chk("s3_ch_e39",    32'(ch_rst), 32'h8);
        step(1);  chk("s3_ch_e40",    32'(ch_rst), 32'h0);
        chk("s3_ready_e40", 32'(ready),     32'd1);
        chk("s3_retry_e40", 32'(retry_cnt), 32'd0);

        // lock_s rises exactly on the timeout cycle: lock wins
        start(1'b0);
        step(17);
        extlock = 1'b1;
        step(2);  chk("s6_pll_e19",   32'(pll_reset), 32'd0);
        step(1);  chk("s6_retry_e20", 32'(retry_cnt), 32'd0);
        chk("s6_pll_e20", 32'(pll_reset), 32'd0);
        step(23); chk("s6_ch_e43",    32'(ch_rst), 32'h8);
        step(1);  chk("s6_ch_e44",    32'(ch_rst), 32'h0);
        chk("s6_ready_e44", 32'(ready), 32'd1);

        // lock_s one cycle late: timeout wins, retry then cleared on SEQ entry (E33)
        start(1'b0);
        step(18);
        extlock = 1'b1;
        step(2);  chk("s6b_retry_e20", 32'(retry_cnt), 32'd1);
        chk("s6b_pll_e20", 32'(pll_reset), 32'd1);
        step(12); chk("s6b_retry_e32", 32'(retry_cnt), 32'd1);
        step(1);  chk("s6b_retry_e33", 32'(retry_cnt), 32'd0);
        step(16); chk("s6b_ch_e49",    32'(ch_rst),    32'h0);
        chk("s6b_ready_e49", 32'(ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
